// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage widths and fetch FSM state encodings.
package fetch_stage_pkg;
  localparam int PC_WIDTH       = 16;
  localparam int IR_WIDTH       = 32;
  localparam int INST_ADDR_SIZE = 6;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry {inst,pc} skid buffer; head visible same cycle, push+pop allowed together.
// Clear wins over push/pop; pushes into a full buffer without a pop are refused.
module fetch_skid_fifo #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [INST_WIDTH-1:0] push_inst,
  input  logic [PC_WIDTH-1:0]   push_pc,
  input  logic                  pop,
  output logic [INST_WIDTH-1:0] head_inst,
  output logic [PC_WIDTH-1:0]   head_pc,
  output logic [1:0]            count
);
  logic [INST_WIDTH-1:0] inst_mem [2];
  logic [PC_WIDTH-1:0]   pc_mem   [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop    = pop & (count != 2'd0);
  assign do_push   = push & ((count != 2'd2) | do_pop);
  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      inst_mem[0] <= '0;
      inst_mem[1] <= '0;
      pc_mem[0]   <= '0;
      pc_mem[1]   <= '0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        inst_mem[wr_ptr] <= push_inst;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads sync imem, buffers in a 2-entry skid FIFO; first valid 2 cycles after first issue.
// Issues only while FIFO + in-flight fit in 2 slots (counting this cycle's pop); redirect flushes everything buffered.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                       PC_WIDTH   = fetch_stage_pkg::PC_WIDTH,
  parameter int                       INST_WIDTH = fetch_stage_pkg::IR_WIDTH,
  parameter int                       IMEM_AW    = fetch_stage_pkg::INST_ADDR_SIZE,
  parameter logic [PC_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lock,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [IMEM_AW-1:0]    imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [PC_WIDTH-1:0]   if_next_pc
);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   inflight_pc;
  logic                  inflight;
  logic                  stale;
  logic [1:0]            fifo_count;
  logic [INST_WIDTH-1:0] head_inst;
  logic [PC_WIDTH-1:0]   head_pc;
  logic                  take_redirect;
  logic                  pop;
  logic                  push;
  logic                  room;
  logic                  issue;

  assign take_redirect = lock & redirect_valid;
  assign pop           = lock & if_valid & if_ready;
  // A slot freed by this cycle's pop is reusable now, which sustains one fetch per cycle.
  assign room  = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign issue = lock & ~redirect_valid & (state != FS_BOOT) & room;
  assign push  = inflight & ~stale;

  assign imem_req   = issue;
  assign imem_addr  = pc[IMEM_AW+1:2];
  assign if_valid   = (fifo_count != 2'd0);
  assign if_inst    = if_valid ? head_inst : '0;
  assign if_pc      = if_valid ? head_pc : '0;
  assign if_next_pc = if_valid ? head_pc + PC_STEP : '0;

  fetch_skid_fifo #(
    .INST_WIDTH (INST_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (take_redirect),
    .push      (push),
    .push_inst (imem_rdata),
    .push_pc   (inflight_pc),
    .pop       (pop),
    .head_inst (head_inst),
    .head_pc   (head_pc),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FS_BOOT;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      stale       <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (lock) begin
        stale <= redirect_valid;
        if (redirect_valid) begin
          pc    <= redirect_pc & ALIGN_MASK;
          state <= FS_FLUSH;
        end else begin
          if (issue) pc <= pc + PC_STEP;
          state <= FS_RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle table plus throughput/stall sequences for fetch_stage.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        lock;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [15:0] if_pc;
  logic [15:0] if_next_pc;
  logic [31:0] imem [64];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .lock           (lock),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_next_pc     (if_next_pc)
  );

  always @(posedge clk) if (imem_req) imem_rdata <= imem[imem_addr];

  typedef struct {
    logic        rst_n;
    logic        lk;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        req;
    logic [5:0]  addr;
    logic        vld;
    logic [15:0] pc;
    logic [15:0] npc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_at(input logic [15:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    if (idx == 6'd0) return 32'h1111_1111;
    if (idx == 6'd1) return 32'h2222_2222;
    return 32'hC0DE_0000 | {26'd0, idx};
  endfunction

  function automatic vec_t v(input logic rst_n, input logic lk, input logic rdy, input logic rv,
                             input logic [15:0] rpc, input logic req, input logic [5:0] addr,
                             input logic vld, input logic [15:0] pc, input logic [15:0] npc,
                             input logic [31:0] inst);
    vec_t r;
    r.rst_n = rst_n; r.lk = lk; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.req = req; r.addr = addr; r.vld = vld; r.pc = pc; r.npc = npc; r.inst = inst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  initial begin
    int exp_pc;
    for (int i = 0; i < 64; i++) imem[i] = inst_at(16'(i * 4));
    reset_n = 1'b0; lock = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // rst lk rdy rv rpc      | req addr vld pc npc inst
    vecs.push_back(v(1,1,1,0,16'h0000, 0,6'h00,0,16'h0000,16'h0000,32'h0));          // R0 boot
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h00,0,16'h0000,16'h0000,32'h0));          // R1
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h01,0,16'h0000,16'h0000,32'h0));          // R2
    vecs.push_back(v(1,1,0,0,16'h0000, 0,6'h00,1,16'h0000,16'h0004,32'h1111_1111));  // R3 stall
    vecs.push_back(v(1,1,0,0,16'h0000, 0,6'h00,1,16'h0000,16'h0004,32'h1111_1111));
    vecs.push_back(v(1,1,0,0,16'h0000, 0,6'h00,1,16'h0000,16'h0004,32'h1111_1111));
    vecs.push_back(v(1,1,0,0,16'h0000, 0,6'h00,1,16'h0000,16'h0004,32'h1111_1111));
    vecs.push_back(v(1,1,0,0,16'h0000, 0,6'h00,1,16'h0000,16'h0004,32'h1111_1111));  // R7
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h02,1,16'h0000,16'h0004,32'h1111_1111));  // R8 release
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h03,1,16'h0004,16'h0008,32'h2222_2222));
    vecs.push_back(v(1,1,0,1,16'h0042, 0,6'h00,1,16'h0008,16'h000C,32'hC0DE_0002));  // R10 redirect
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h10,0,16'h0000,16'h0000,32'h0));          // R11 flush
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h11,0,16'h0000,16'h0000,32'h0));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h12,1,16'h0040,16'h0044,32'hC0DE_0010));
    vecs.push_back(v(1,1,1,1,16'h0010, 0,6'h00,1,16'h0044,16'h0048,32'hC0DE_0011));  // R14 redirect+xfer
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h04,0,16'h0000,16'h0000,32'h0));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h05,0,16'h0000,16'h0000,32'h0));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h06,1,16'h0010,16'h0014,32'hC0DE_0004));
    vecs.push_back(v(1,0,1,0,16'h0000, 0,6'h00,1,16'h0014,16'h0018,32'hC0DE_0005));  // R18 lock=0
    vecs.push_back(v(1,0,1,0,16'h0000, 0,6'h00,1,16'h0014,16'h0018,32'hC0DE_0005));
    vecs.push_back(v(1,0,1,1,16'h0080, 0,6'h00,1,16'h0014,16'h0018,32'hC0DE_0005));  // redirect ignored
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h07,1,16'h0014,16'h0018,32'hC0DE_0005));  // R21 resume
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h08,1,16'h0018,16'h001C,32'hC0DE_0006));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h09,1,16'h001C,16'h0020,32'hC0DE_0007));
    vecs.push_back(v(1,1,1,1,16'hFFFE, 0,6'h00,1,16'h0020,16'h0024,32'hC0DE_0008));  // R24 to 0xFFFC
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h3F,0,16'h0000,16'h0000,32'h0));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h00,0,16'h0000,16'h0000,32'h0));          // pc wrapped
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h01,1,16'hFFFC,16'h0000,32'hC0DE_003F));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h02,1,16'h0000,16'h0004,32'h1111_1111));
    vecs.push_back(v(0,1,1,0,16'h0000, 1,6'h03,1,16'h0004,16'h0008,32'h2222_2222));  // R29 reset
    vecs.push_back(v(1,1,1,0,16'h0000, 0,6'h00,0,16'h0000,16'h0000,32'h0));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h00,0,16'h0000,16'h0000,32'h0));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h01,0,16'h0000,16'h0000,32'h0));
    vecs.push_back(v(1,1,1,0,16'h0000, 1,6'h02,1,16'h0000,16'h0004,32'h1111_1111));  // R33 restart

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_if_pc", 32'(if_pc), 32'h0);
    chk("rst_if_next_pc", 32'(if_next_pc), 32'h0);
    @(posedge clk);

    foreach (vecs[i]) begin
      #1;
      reset_n = vecs[i].rst_n; lock = vecs[i].lk; if_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      @(negedge clk);
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("row%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(vecs[i].vld));
      chk($sformatf("row%0d_pc", i), 32'(if_pc), 32'(vecs[i].pc));
      chk($sformatf("row%0d_next_pc", i), 32'(if_next_pc), 32'(vecs[i].npc));
      chk($sformatf("row%0d_inst", i), if_inst, vecs[i].inst);
      @(posedge clk);
    end

    // Sustained streaming: one new pc every cycle.
    redirect_valid = 1'b0;
    exp_pc = 4;
    for (int c = 0; c < 6; c++) begin
      #1 if_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("stream%0d_valid", c), 32'(if_valid), 32'h1);
      chk($sformatf("stream%0d_pc", c), 32'(if_pc), 32'(exp_pc));
      chk($sformatf("stream%0d_inst", c), if_inst, inst_at(16'(exp_pc)));
      exp_pc += 4;
      @(posedge clk);
    end
    // Stall: head held stable, no issue once full.
    for (int c = 0; c < 4; c++) begin
      #1 if_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("stall%0d_pc", c), 32'(if_pc), 32'(exp_pc));
      chk($sformatf("stall%0d_inst", c), if_inst, inst_at(16'(exp_pc)));
      chk($sformatf("stall%0d_req", c), 32'(imem_req), 32'h0);
      @(posedge clk);
    end
    // Release: no loss or duplication.
    for (int c = 0; c < 4; c++) begin
      #1 if_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("release%0d_valid", c), 32'(if_valid), 32'h1);
      chk($sformatf("release%0d_pc", c), 32'(if_pc), 32'(exp_pc));
      chk($sformatf("release%0d_next_pc", c), 32'(if_next_pc), 32'(16'(exp_pc + 4)));
      exp_pc += 4;
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
